// File: rtl/bus_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_xfer_sequencer
//  Purpose  : Queues register-to-register move requests (src, dst) for a
//             shared register bus and issues one-hot bus-drive (o_reg_out)
//             and bus-latch (o_reg_in) enables. Each move takes two cycles:
//             a settle cycle (source drives only), then a latch cycle
//             (source drives, destination latches). At most one driver is
//             enabled per cycle.
//  Ports    : i_clk, i_rst (async, active-high)
//             i_req_valid / o_req_ready      request handshake (ready = !full)
//             i_req_src, i_req_dst           register indices of the move
//             o_reg_out, o_reg_in            one-hot drive / latch enables
//             o_xfer_done                    pulse in the latch cycle
//             o_req_err                      pulse for a dropped illegal move
//             o_busy                         queue non-empty or FSM active
//             o_xfer_count (XFER_COUNT_EN)   16-bit wrapping count of latches
//  Options  : define XFER_COUNT_EN to add the o_xfer_count output.
//  Revision : 1.0  initial release
// ============================================================================
module bus_xfer_sequencer #(
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [IDX_W-1:0]    i_req_src,
  input  logic [IDX_W-1:0]    i_req_dst,
  output logic [NUM_REGS-1:0] o_reg_out,
  output logic [NUM_REGS-1:0] o_reg_in,
  output logic                o_xfer_done,
  output logic                o_req_err,
  output logic                o_busy
`ifdef XFER_COUNT_EN
  ,
  output logic [15:0]         o_xfer_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]    c_depth    = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    c_cnt_one  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  c_ptr_one  = PTR_W'(1);
  localparam logic [IDX_W:0]    c_num_regs = (IDX_W+1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] c_one_hot = NUM_REGS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  // Request queue
  logic [IDX_W-1:0] r_fifo_src [FIFO_DEPTH];
  logic [IDX_W-1:0] r_fifo_dst [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Sequencer state and registered outputs
  state_t           r_state;
  logic [IDX_W-1:0] r_cur_src;
  logic [IDX_W-1:0] r_cur_dst;
  logic [NUM_REGS-1:0] r_reg_out;
  logic [NUM_REGS-1:0] r_reg_in;
  logic             r_xfer_done;
  logic             r_req_err;
  logic             r_busy;
  logic             r_req_ready;

  logic             w_hs;
  logic             w_illegal;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W:0]   w_count_nxt;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_src_nxt;
  logic [IDX_W-1:0] w_dst_nxt;
  logic [NUM_REGS-1:0] w_reg_out_nxt;
  logic [NUM_REGS-1:0] w_reg_in_nxt;
  logic             w_done_nxt;

  assign w_hs      = i_req_valid && r_req_ready;
  assign w_illegal = (i_req_src == i_req_dst) ||
                     ({1'b0, i_req_src} >= c_num_regs) ||
                     ({1'b0, i_req_dst} >= c_num_regs);
  assign w_push    = w_hs && !w_illegal;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_one;
      2'b01:   w_count_nxt = r_count - c_cnt_one;
      default: w_count_nxt = r_count;
    endcase
  end

  // Next state plus the output values that state will present. Outputs are
  // computed one cycle early so they can be driven straight from flops.
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_src_nxt     = r_cur_src;
    w_dst_nxt     = r_cur_dst;
    w_reg_out_nxt = '0;
    w_reg_in_nxt  = '0;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE, S_XFER: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
          w_src_nxt   = r_fifo_src[r_rd_ptr];
          w_dst_nxt   = r_fifo_dst[r_rd_ptr];
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: w_state_nxt = S_XFER;
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_SETUP: w_reg_out_nxt = c_one_hot << w_src_nxt;
      S_XFER: begin
        w_reg_out_nxt = c_one_hot << w_src_nxt;
        w_reg_in_nxt  = c_one_hot << w_dst_nxt;
        w_done_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  // Queue storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_src[r_wr_ptr] <= i_req_src;
      r_fifo_dst[r_wr_ptr] <= i_req_dst;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_cur_src   <= '0;
      r_cur_dst   <= '0;
      r_reg_out   <= '0;
      r_reg_in    <= '0;
      r_xfer_done <= 1'b0;
      r_req_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      r_count     <= w_count_nxt;
      r_state     <= w_state_nxt;
      r_cur_src   <= w_src_nxt;
      r_cur_dst   <= w_dst_nxt;
      r_reg_out   <= w_reg_out_nxt;
      r_reg_in    <= w_reg_in_nxt;
      r_xfer_done <= w_done_nxt;
      r_req_err   <= w_hs && w_illegal;
      r_busy      <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
      r_req_ready <= (w_count_nxt != c_depth);
    end
  end

`ifdef XFER_COUNT_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_xfer_count <= 16'd0;
    end else if (r_state == S_XFER) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign o_xfer_count = r_xfer_count;
`endif

  assign o_req_ready = r_req_ready;
  assign o_reg_out   = r_reg_out;
  assign o_reg_in    = r_reg_in;
  assign o_xfer_done = r_xfer_done;
  assign o_req_err   = r_req_err;
  assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_xfer_sequencer
//  Purpose  : Self-checking bench for bus_xfer_sequencer (8 registers,
//             4-bit indices so out-of-range indices can be driven, depth 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_xfer_sequencer;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_src;
  logic [3:0] req_dst;
  logic [7:0] reg_out;
  logic [7:0] reg_in;
  logic       xfer_done;
  logic       req_err;
  logic       busy;
`ifdef XFER_COUNT_EN
  logic [15:0] xfer_count;
`endif

  bus_xfer_sequencer #(
    .NUM_REGS   (8),
    .IDX_W      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_src    (req_src),
    .i_req_dst    (req_dst),
    .o_reg_out    (reg_out),
    .o_reg_in     (reg_in),
    .o_xfer_done  (xfer_done),
    .o_req_err    (req_err),
    .o_busy       (busy)
`ifdef XFER_COUNT_EN
    ,
    .o_xfer_count (xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;

  logic [7:0] sb_q [$];

  typedef struct {
    logic [3:0] src;
    logic [3:0] dst;
    logic       err;
    logic [7:0] out_exp;
    logic [7:0] in_exp;
  } vec_t;

  vec_t vecs [7];

  logic [7:0] seq_out [6] = '{8'h02, 8'h02, 8'h08, 8'h08, 8'h10, 8'h10};
  logic [7:0] seq_in  [6] = '{8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h01};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: every latch cycle must match the oldest accepted legal move.
  always @(negedge clk) begin
    if (!rst && xfer_done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        chk("sb_reg_out", reg_out, 8'h01 << e[7:4]);
        chk("sb_reg_in",  reg_in,  8'h01 << e[3:0]);
      end
    end
  end

  // One-hot / exclusivity invariants, every cycle.
  always @(negedge clk) begin
    chk("inv_out_onehot", ($countones(reg_out) <= 1), 32'd1);
    chk("inv_in_onehot",  ($countones(reg_in) <= 1), 32'd1);
    chk("inv_in_needs_out", (reg_in == 8'h00) || (reg_out != 8'h00), 32'd1);
    chk("inv_same_index", reg_in & reg_out, 32'd0);
  end

  task automatic drive_req(input logic [3:0] s, input logic [3:0] d, input logic legal);
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    if (req_ready && legal) sb_q.push_back({s, d});
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("timeout_wait_idle", 32'd1, 32'd0);
  endtask

  // Single request into an idle, empty block, checked cycle by cycle.
  task automatic run_single(input vec_t v, input string tag);
    @(negedge clk);
    drive_req(v.src, v.dst, !v.err);
    @(negedge clk);                     // after E0
    req_valid = 1'b0;
    chk({tag, "_err"},  req_err, v.err);
    chk({tag, "_busy"}, busy, !v.err);
    chk({tag, "_out0"}, reg_out, 8'h00);
    @(negedge clk);                     // after E0+1: SETUP
    chk({tag, "_out1"}, reg_out, v.out_exp);
    chk({tag, "_in1"},  reg_in, 8'h00);
    @(negedge clk);                     // after E0+2: XFER
    chk({tag, "_out2"},  reg_out, v.out_exp);
    chk({tag, "_in2"},   reg_in, v.in_exp);
    chk({tag, "_done2"}, xfer_done, !v.err);
    @(negedge clk);                     // after E0+3: IDLE
    chk({tag, "_out3"},  reg_out, 8'h00);
    chk({tag, "_in3"},   reg_in, 8'h00);
    chk({tag, "_busy3"}, busy, 1'b0);
  endtask

  initial begin
    int done0;
    int acc;
    bit full_seen;

    vecs[0] = '{4'd2, 4'd5, 1'b0, 8'h04, 8'h20};
    vecs[1] = '{4'd7, 4'd0, 1'b0, 8'h80, 8'h01};
    vecs[2] = '{4'd0, 4'd7, 1'b0, 8'h01, 8'h80};
    vecs[3] = '{4'd6, 4'd6, 1'b1, 8'h00, 8'h00};
    vecs[4] = '{4'd1, 4'd9, 1'b1, 8'h00, 8'h00};
    vecs[5] = '{4'd8, 4'd1, 1'b1, 8'h00, 8'h00};
    vecs[6] = '{4'd5, 4'd3, 1'b0, 8'h20, 8'h08};

    rst = 1'b1;
    req_valid = 1'b0;
    req_src = '0;
    req_dst = '0;
    repeat (2) @(negedge clk);
    chk("rst_out",   reg_out, 8'h00);
    chk("rst_in",    reg_in, 8'h00);
    chk("rst_done",  xfer_done, 1'b0);
    chk("rst_err",   req_err, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
`ifdef XFER_COUNT_EN
    chk("rst_count", xfer_count, 16'h0000);
`endif
    rst = 1'b0;

    // Table of single requests: legal, corner indices, illegal drops.
    for (int i = 0; i < 7; i++) begin
      run_single(vecs[i], $sformatf("vec%0d", i));
    end

    // Three back-to-back moves: no idle gap between them.
    wait_idle();
    done0 = n_done;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 7) begin
        chk($sformatf("b2b_out%0d", k - 2), reg_out, seq_out[k-2]);
        chk($sformatf("b2b_in%0d", k - 2),  reg_in,  seq_in[k-2]);
      end
      case (k)
        0: drive_req(4'd1, 4'd3, 1'b1);
        1: drive_req(4'd3, 4'd4, 1'b1);
        2: drive_req(4'd4, 4'd0, 1'b1);
        default: req_valid = 1'b0;
      endcase
    end
    chk("b2b_done_count", n_done - done0, 32'd3);
    chk("b2b_idle_out", reg_out, 8'h00);

    // Hold valid continuously: the queue fills while the FSM drains.
    wait_idle();
    done0 = n_done;
    acc = 0;
    full_seen = 1'b0;
    for (int c = 0; c < 20 && !full_seen; c++) begin
      @(negedge clk);
      if (req_ready) begin
        drive_req(4'(acc % 8), 4'((acc + 3) % 8), 1'b1);
        acc++;
      end else begin
        full_seen = 1'b1;
      end
    end
    chk("fill_full_seen", full_seen, 1'b1);
    chk("fill_accepted", acc, 32'd7);
    chk("fill_ready_low", req_ready, 1'b0);
    @(negedge clk);
    chk("fill_ready_back", req_ready, 1'b1);
    drive_req(4'(acc % 8), 4'((acc + 3) % 8), 1'b1);
    acc++;
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    chk("fill_all_drained", n_done - done0, acc);
    chk("fill_sb_empty", sb_q.size(), 32'd0);

    // Reset asserted during the latch cycle of 3->1, with 2->4 still queued.
    wait_idle();
    @(negedge clk);
    drive_req(4'd3, 4'd1, 1'b1);
    @(negedge clk);
    drive_req(4'd2, 4'd4, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_xfer_out", reg_out, 8'h08);
    chk("rstmid_xfer_in",  reg_in,  8'h02);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_out",   reg_out, 8'h00);
    chk("rstmid_in",    reg_in, 8'h00);
    chk("rstmid_busy",  busy, 1'b0);
    chk("rstmid_ready", req_ready, 1'b1);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    done0 = n_done;
    repeat (4) @(negedge clk);
    chk("rstmid_no_done", n_done - done0, 32'd0);
    chk("rstmid_flushed", busy, 1'b0);
    run_single(vecs[0], "rstmid_fresh");

`ifdef XFER_COUNT_EN
    wait_idle();
    force dut.r_xfer_count = 16'hFFFC;
    @(negedge clk);
    release dut.r_xfer_count;
    for (int i = 0; i < 2; i++) run_single(vecs[6], "cnt_pre");
    chk("cnt_preload", xfer_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) run_single(vecs[1], "cnt_wrap");
    chk("cnt_wrapped", xfer_count, 16'h0001);
    run_single(vecs[3], "cnt_illegal");
    chk("cnt_no_illegal", xfer_count, 16'h0001);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
